lsu_align: RTL and testbench

Load/store unit between the MEM-stage control and the Avalon-MM data memory port of the Cyclone II system. It accepts one load or store per instruction, drives byte enables and replicated store data, and holds the pipeline via `stall` until the bus transaction completes. It returns load data right-aligned (addressed byte or halfword at bit 0) to the load-extension mux, which applies sign or zero extension. It also flags misaligned, illegal-size and timed-out accesses.

---
 rtl/lsu_align.sv | 228 ++++++++++++++++++++++
 tb/tb_lsu_align.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the MEM-stage control and an
// Avalon-MM data memory port. One access per instruction: it decodes the size
// code, rejects illegal or misaligned accesses, drives lane-replicated store
// data with byte enables, returns load data right-aligned, and aborts an access
// that stays in REQ+RESP for TIMEOUT cycles.
module lsu_align #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_byteenable,
    output logic [31:0] bus_writedata,
    input  logic [31:0] bus_readdata,
    input  logic        bus_waitrequest,
    input  logic        bus_readdatavalid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Last counter value at which the access is still allowed to complete;
    // reaching it without completion aborts on that same cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    // Size codes: 000 B, 001 H, 010 W, 100 BU, 101 HU. Unsigned forms are
    // load-only; halfwords need even addresses, words need 4-byte alignment.
    function automatic logic access_illegal(input logic       we,
                                            input logic [2:0] f3,
                                            input logic [1:0] a_lo);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a_lo[0];
            3'b010:  bad = (a_lo != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | a_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte-lane mask for the addressed byte, halfword or word.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3,
                                             input logic [1:0] a_lo);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << a_lo;
            2'b01:   m = 4'b0011 << {a_lo[1], 1'b0};
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Store data replicated across every lane so the mask alone picks the bytes.
    function automatic logic [31:0] lane_data(input logic [2:0]  f3,
                                              input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Right-align a read word so the addressed byte lands at bit 0 (zero fill).
    function automatic logic [31:0] align_load(input logic [31:0] rd,
                                               input logic [1:0]  off);
        return rd >> {off, 3'b000};
    endfunction

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic        done_q;
    logic        fault_q;
    logic [31:0] rdata_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;
    logic        rd_q;
    logic        wr_q;

    logic        illegal_d;
    logic [3:0]  be_d;
    logic [31:0] wd_d;
    logic [7:0]  cnt_d;
    logic        timed_out_d;

    // Decode the incoming request and compute the saturating timeout count.
    always_comb begin
        illegal_d   = access_illegal(mem_we, funct3, addr[1:0]);
        be_d        = lane_mask(funct3, addr[1:0]);
        wd_d        = lane_data(funct3, wdata);
        timed_out_d = (cnt_q >= CNT_LAST);
        if (cnt_q == 8'hFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Access sequencer: state, bus strobes/fields and the completion flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            off_q   <= 2'b00;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
            addr_q  <= 32'd0;
            be_q    <= 4'b0000;
            wd_q    <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    if (mem_valid && illegal_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                    end else if (mem_valid) begin
                        state_q <= ST_REQ;
                        cnt_q   <= 8'd0;
                        off_q   <= addr[1:0];
                        addr_q  <= {addr[31:2], 2'b00};
                        be_q    <= be_d;
                        wd_q    <= wd_d;
                        rd_q    <= ~mem_we;
                        wr_q    <= mem_we;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_d;
                    if (!bus_waitrequest) begin
                        // Accepted: loads wait for data, stores are finished.
                        rd_q <= 1'b0;
                        wr_q <= 1'b0;
                        if (rd_q) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            fault_q <= 1'b0;
                        end
                    end else if (timed_out_d) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                        rdata_q <= 32'd0;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    cnt_q <= cnt_d;
                    if (bus_readdatavalid) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        fault_q <= 1'b0;
                        rdata_q <= align_load(bus_readdata, off_q);
                    end else if (timed_out_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                        rdata_q <= 32'd0;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                ST_DONE: begin
                    // The pipeline advances this cycle; never relaunch here.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline hold: request pending in IDLE, or bus transaction in flight.
    always_comb begin
        stall = reset_n & (((state_q == ST_IDLE) & mem_valid) |
                           (state_q == ST_REQ) | (state_q == ST_RESP));
    end

    assign done           = done_q;
    assign fault          = fault_q;
    assign rdata          = rdata_q;
    assign bus_address    = addr_q;
    assign bus_read       = rd_q;
    assign bus_write      = wr_q;
    assign bus_byteenable = be_q;
    assign bus_writedata  = wd_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: a small Avalon slave driven per cycle from
// per-vector wait/latency settings; results compared to hand-computed values.
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_writedata;
    logic [31:0] bus_readdata;
    logic        bus_waitrequest;
    logic        bus_readdatavalid;

    int n_chk  = 0;
    int n_pass = 0;

    lsu_align #(.TIMEOUT(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mem_valid         (mem_valid),
        .mem_we            (mem_we),
        .funct3            (funct3),
        .addr              (addr),
        .wdata             (wdata),
        .stall             (stall),
        .done              (done),
        .fault             (fault),
        .rdata             (rdata),
        .bus_address       (bus_address),
        .bus_read          (bus_read),
        .bus_write         (bus_write),
        .bus_byteenable    (bus_byteenable),
        .bus_writedata     (bus_writedata),
        .bus_readdata      (bus_readdata),
        .bus_waitrequest   (bus_waitrequest),
        .bus_readdatavalid (bus_readdatavalid)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // One access from mem_valid rise to done; cycle 1 is the IDLE request cycle.
    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input int rdv_dly, input logic spurious,
                          input logic [31:0] rd_good,
                          output int dcyc, output int stl, output int nrd, output int nwr,
                          output logic [31:0] cap_addr, output logic [31:0] cap_be,
                          output logic [31:0] cap_wd, output logic [31:0] rdat,
                          output logic flt);
        int   acc;
        int   wc;
        logic seen;
        logic strb;
        logic acc_now;
        dcyc = 0; stl = 0; nrd = 0; nwr = 0;
        cap_addr = 32'd0; cap_be = 32'd0; cap_wd = 32'd0; rdat = 32'd0; flt = 1'b0;
        acc = 0; wc = 0; seen = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            strb              = bus_read | bus_write;
            bus_waitrequest   = strb && (wc < waits);
            acc_now           = strb && !bus_waitrequest;
            bus_readdatavalid = (acc > 0 && cyc == acc + rdv_dly) || (spurious && acc_now);
            bus_readdata      = acc_now ? 32'hDEADBEEF : rd_good;
            #1;
            if (stall)     stl++;
            if (bus_read)  nrd++;
            if (bus_write) nwr++;
            if (strb && !seen) begin
                seen     = 1'b1;
                cap_addr = bus_address;
                cap_be   = {28'd0, bus_byteenable};
                cap_wd   = bus_writedata;
            end
            if (bus_waitrequest) wc++;
            if (acc_now) acc = cyc;
            if (done) begin
                dcyc = cyc;
                rdat = rdata;
                flt  = fault;
                chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
                break;
            end
        end
        mem_valid = 1'b0; bus_waitrequest = 1'b0; bus_readdatavalid = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    int          dc, st, nr, nw;
    logic [31:0] ca, cb, cw, rd;
    logic        fl;

    initial begin
        reset_n = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; funct3 = 3'b000;
        addr = 32'd0; wdata = 32'd0; bus_readdata = 32'd0;
        bus_waitrequest = 1'b0; bus_readdatavalid = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_rd",    {31'd0, bus_read},  32'd0);
        chk("rst_wr",    {31'd0, bus_write}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr",  bus_address, 32'd0);
        chk("rst_be",    {28'd0, bus_byteenable}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Store byte at offset 3.
        run_op("sb", 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 1'b0, 32'd0,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("sb_cycles", dc, 3);  chk("sb_stall", st, 2);
        chk("sb_nwr", nw, 1);     chk("sb_nrd", nr, 0);
        chk("sb_addr", ca, 32'h0000_1000);
        chk("sb_be", cb, 32'h8);  chk("sb_wd", cw, 32'hDDDD_DDDD);
        chk("sb_fault", {31'd0, fl}, 32'd0);

        // Load halfword at offset 2, data one cycle after acceptance.
        run_op("lh", 1'b0, 3'b001, 32'h0000_2002, 32'd0, 0, 1, 1'b0, 32'h8765_4321,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("lh_cycles", dc, 4);  chk("lh_stall", st, 3);
        chk("lh_nrd", nr, 1);     chk("lh_be", cb, 32'hC);
        chk("lh_rdata", rd, 32'h0000_8765);
        chk("lh_fault", {31'd0, fl}, 32'd0);

        // Load word with 4 waitrequest cycles and 2-cycle read latency.
        run_op("lw_wait", 1'b0, 3'b010, 32'h0000_3000, 32'd0, 4, 2, 1'b0, 32'hCAFE_F00D,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("lw_wait_cycles", dc, 9); chk("lw_wait_stall", st, 8);
        chk("lw_wait_nrd", nr, 5);    chk("lw_wait_be", cb, 32'hF);
        chk("lw_wait_rdata", rd, 32'hCAFE_F00D);

        // Load byte unsigned at offset 1; readdatavalid in acceptance cycle ignored.
        run_op("lbu_spur", 1'b0, 3'b100, 32'h0000_4001, 32'd0, 0, 2, 1'b1, 32'h1122_3344,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("lbu_spur_cycles", dc, 5); chk("lbu_spur_be", cb, 32'h2);
        chk("lbu_spur_rdata", rd, 32'h0011_2233);

        // Illegal accesses: no strobe, fault on cycle 2, rdata unchanged.
        run_op("lw_mis", 1'b0, 3'b010, 32'h0000_0006, 32'd0, 0, 1, 1'b0, 32'hFFFF_FFFF,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("lw_mis_cycles", dc, 2); chk("lw_mis_stall", st, 1);
        chk("lw_mis_nrd", nr, 0);    chk("lw_mis_fault", {31'd0, fl}, 32'd1);
        chk("lw_mis_rdata", rd, 32'h0011_2233);
        run_op("sbu", 1'b1, 3'b100, 32'h0000_0010, 32'h0000_0055, 0, 0, 1'b0, 32'd0,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("sbu_cycles", dc, 2);    chk("sbu_nwr", nw, 0);
        chk("sbu_fault", {31'd0, fl}, 32'd1);
        chk("sbu_rdata", rd, 32'h0011_2233);
        run_op("f011", 1'b0, 3'b011, 32'h0000_0020, 32'd0, 0, 1, 1'b0, 32'd0,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("f011_cycles", dc, 2);   chk("f011_fault", {31'd0, fl}, 32'd1);
        run_op("lhu_odd", 1'b0, 3'b101, 32'h0000_5001, 32'd0, 0, 1, 1'b0, 32'd0,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("lhu_odd_cycles", dc, 2); chk("lhu_odd_nrd", nr, 0);
        chk("lhu_odd_fault", {31'd0, fl}, 32'd1);

        // Reset asserted while the load sits in RESP.
        @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_7000;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_rd",    {31'd0, bus_read}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_addr",  bus_address, 32'd0);
        chk("mid_rst_be",    {28'd0, bus_byteenable}, 32'd0);
        chk("mid_rst_wd",    bus_writedata, 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_readdatavalid = 1'b1; bus_readdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_readdatavalid = 1'b0;
        #1;
        chk("late_rdv_done",  {31'd0, done}, 32'd0);
        chk("late_rdv_rdata", rdata, 32'd0);

        // Normal traffic after the reset.
        run_op("sh", 1'b1, 3'b001, 32'h0000_8002, 32'h1234_5678, 0, 0, 1'b0, 32'd0,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("sh_cycles", dc, 3); chk("sh_addr", ca, 32'h0000_8000);
        chk("sh_be", cb, 32'hC); chk("sh_wd", cw, 32'h5678_5678);
        run_op("sw", 1'b1, 3'b010, 32'h0000_9000, 32'h0BAD_F00D, 0, 0, 1'b0, 32'd0,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("sw_be", cb, 32'hF); chk("sw_wd", cw, 32'h0BAD_F00D);
        run_op("lb", 1'b0, 3'b000, 32'h0000_9002, 32'd0, 0, 1, 1'b0, 32'hA1B2_C3D4,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("lb_be", cb, 32'h4); chk("lb_rdata", rd, 32'h0000_A1B2);

        // Slave never releases waitrequest: abort after 8 cycles of bus_read.
        run_op("lw_to", 1'b0, 3'b010, 32'h0000_A000, 32'd0, 1000, 1, 1'b0, 32'h0000_0001,
               dc, st, nr, nw, ca, cb, cw, rd, fl);
        chk("lw_to_nrd", nr, 8);     chk("lw_to_cycles", dc, 10);
        chk("lw_to_stall", st, 9);   chk("lw_to_fault", {31'd0, fl}, 32'd1);
        chk("lw_to_rdata", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
